response_tree_pipe_l2: RTL and testbench

// - Parametrised, optionally pipelined N-to-1 response fan-in tree for the L2 crossbar (one per master port).
// - Merges per-slave read responses (valid/rdata/rtag) into one response channel.
// - Supports any N_SLAVE, not just powers of two.
// - Registers are placed at selectable tree levels.
// - Detects response collisions (more than one slave valid in the same cycle) and flags them.

---
 rtl/response_tree_pipe_l2.sv | 144 ++++++++++++++
 tb/tb_response_tree_pipe_l2.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/response_tree_pipe_l2.sv
// N-to-1 read-response fan-in tree with per-level optional pipeline registers and collision flagging.
// Optional collision counter is built when RESP_TREE_COLL_CNT_EN is defined.
module response_tree_pipe_l2 #(
  parameter int unsigned N_SLAVE    = 4,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned TAG_WIDTH  = 8,
  parameter int unsigned REG_MASK   = 0,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_SLAVE-1:0]              data_r_valid_i,
  input  logic [N_SLAVE*DATA_WIDTH-1:0]   data_r_rdata_i,
  input  logic [N_SLAVE*TAG_WIDTH-1:0]    data_r_rtag_i,
  output logic                            data_r_valid_o,
  output logic [DATA_WIDTH-1:0]           data_r_rdata_o,
  output logic [TAG_WIDTH-1:0]            data_r_rtag_o,
  input  logic                            coll_clear_i,
  output logic                            coll_o,
  output logic [CNT_WIDTH-1:0]            coll_cnt_o
);

  function automatic int unsigned popcnt(input int unsigned m, input int unsigned n);
    int unsigned c;
    c = 0;
    for (int unsigned i = 0; i < n; i++) c += (m >> i) & 1;
    return c;
  endfunction

  localparam int unsigned LOG_SLAVE = (N_SLAVE <= 2) ? 1 : $clog2(N_SLAVE);
  localparam int unsigned NP        = 1 << LOG_SLAVE;
  localparam int unsigned DW        = DATA_WIDTH;
  localparam int unsigned TW        = TAG_WIDTH;
  localparam int unsigned LAT       = popcnt(REG_MASK, LOG_SLAVE);

  // Inputs zero-extended to a full power-of-two leaf row
  logic [NP-1:0]    pad_v;
  logic [NP*DW-1:0] pad_d;
  logic [NP*TW-1:0] pad_t;

  assign pad_v = NP'(data_r_valid_i);
  assign pad_d = (NP*DW)'(data_r_rdata_i);
  assign pad_t = (NP*TW)'(data_r_rtag_i);

  for (genvar l = 0; l < LOG_SLAVE; l++) begin : g_lvl
    localparam int unsigned NN = NP >> (l + 1);

    logic [2*NN-1:0]    iv;
    logic [2*NN*DW-1:0] id;
    logic [2*NN*TW-1:0] it;
    logic [NN-1:0]      cv;
    logic [NN*DW-1:0]   cd;
    logic [NN*TW-1:0]   ct;
    logic [NN-1:0]      ov;
    logic [NN*DW-1:0]   od;
    logic [NN*TW-1:0]   ot;

    if (l == 0) begin : g_src
      assign iv = pad_v;
      assign id = pad_d;
      assign it = pad_t;
    end else begin : g_src
      assign iv = g_lvl[l-1].ov;
      assign id = g_lvl[l-1].od;
      assign it = g_lvl[l-1].ot;
    end

    // Lower input wins; idle node outputs are all-zero
    for (genvar n = 0; n < NN; n++) begin : g_node
      assign cv[n] = iv[2*n] | iv[2*n+1];
      assign cd[n*DW +: DW] = iv[2*n]   ? id[2*n*DW +: DW] :
                              iv[2*n+1] ? id[(2*n+1)*DW +: DW] : '0;
      assign ct[n*TW +: TW] = iv[2*n]   ? it[2*n*TW +: TW] :
                              iv[2*n+1] ? it[(2*n+1)*TW +: TW] : '0;
    end

    if (((REG_MASK >> l) & 1) != 0) begin : g_reg
      always_ff @(posedge clk) begin
        if (rst) begin
          ov <= '0;
          od <= '0;
          ot <= '0;
        end else begin
          ov <= cv;
          od <= cd;
          ot <= ct;
        end
      end
    end else begin : g_comb
      assign ov = cv;
      assign od = cd;
      assign ot = ct;
    end
  end

  assign data_r_valid_o = g_lvl[LOG_SLAVE-1].ov[0];
  assign data_r_rdata_o = g_lvl[LOG_SLAVE-1].od[DW-1:0];
  assign data_r_rtag_o  = g_lvl[LOG_SLAVE-1].ot[TW-1:0];

  // More than one valid bit set at the inputs
  logic [N_SLAVE-1:0] valid_m1;
  logic               coll_now;
  logic               coll_dly;

  assign valid_m1 = data_r_valid_i - N_SLAVE'(1);
  assign coll_now = |(data_r_valid_i & valid_m1);

  if (LAT == 0) begin : g_cdly
    assign coll_dly = coll_now;
  end else begin : g_cdly
    logic [LAT-1:0] sr;
    always_ff @(posedge clk) begin
      if (rst) sr <= '0;
      else     sr <= (sr << 1) | LAT'(coll_now);
    end
    assign coll_dly = sr[LAT-1];
  end

  // Sticky flag; the delayed event is OR-ed in so the flag rises with its beat
  logic coll_q;

  always_ff @(posedge clk) begin
    if (rst)               coll_q <= 1'b0;
    else if (coll_dly)     coll_q <= 1'b1;
    else if (coll_clear_i) coll_q <= 1'b0;
  end

  assign coll_o = coll_q | coll_dly;

`ifdef RESP_TREE_COLL_CNT_EN
  logic [CNT_WIDTH-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst)                          cnt_q <= '0;
    else if (coll_clear_i)            cnt_q <= CNT_WIDTH'(coll_dly);
    else if (coll_dly && cnt_q != '1) cnt_q <= cnt_q + CNT_WIDTH'(1);
  end

  assign coll_cnt_o = cnt_q;
`else
  assign coll_cnt_o = '0;
`endif

endmodule

// File: tb/tb_response_tree_pipe_l2.sv
// Directed bench for response_tree_pipe_l2: combinational, pipelined and single-slave instances.
module tb_response_tree_pipe_l2;

  localparam int unsigned DW = 16;
  localparam int unsigned TW = 8;
  localparam int unsigned CW = 2;
`ifdef RESP_TREE_COLL_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  logic [4:0]      v5;
  logic [5*DW-1:0] d5;
  logic [5*TW-1:0] t5;
  logic            clr5;
  logic            ov5;
  logic [DW-1:0]   od5;
  logic [TW-1:0]   ot5;
  logic            coll5;
  logic [CW-1:0]   cnt5;

  logic [7:0]      v8;
  logic [8*DW-1:0] d8;
  logic [8*TW-1:0] t8;
  logic            clr8;
  logic            ov8;
  logic [DW-1:0]   od8;
  logic [TW-1:0]   ot8;
  logic            coll8;
  logic [CW-1:0]   cnt8;

  logic [0:0]      v1;
  logic [DW-1:0]   d1;
  logic [TW-1:0]   t1;
  logic            clr1;
  logic            ov1;
  logic [DW-1:0]   od1;
  logic [TW-1:0]   ot1;
  logic            coll1;
  logic [CW-1:0]   cnt1;

  response_tree_pipe_l2 #(.N_SLAVE(5), .DATA_WIDTH(DW), .TAG_WIDTH(TW), .REG_MASK(0), .CNT_WIDTH(CW)) u5 (
    .clk(clk), .rst(rst), .data_r_valid_i(v5), .data_r_rdata_i(d5), .data_r_rtag_i(t5),
    .data_r_valid_o(ov5), .data_r_rdata_o(od5), .data_r_rtag_o(ot5),
    .coll_clear_i(clr5), .coll_o(coll5), .coll_cnt_o(cnt5));

  response_tree_pipe_l2 #(.N_SLAVE(8), .DATA_WIDTH(DW), .TAG_WIDTH(TW), .REG_MASK(5), .CNT_WIDTH(CW)) u8 (
    .clk(clk), .rst(rst), .data_r_valid_i(v8), .data_r_rdata_i(d8), .data_r_rtag_i(t8),
    .data_r_valid_o(ov8), .data_r_rdata_o(od8), .data_r_rtag_o(ot8),
    .coll_clear_i(clr8), .coll_o(coll8), .coll_cnt_o(cnt8));

  response_tree_pipe_l2 #(.N_SLAVE(1), .DATA_WIDTH(DW), .TAG_WIDTH(TW), .REG_MASK(1), .CNT_WIDTH(CW)) u1 (
    .clk(clk), .rst(rst), .data_r_valid_i(v1), .data_r_rdata_i(d1), .data_r_rtag_i(t1),
    .data_r_valid_o(ov1), .data_r_rdata_o(od1), .data_r_rtag_o(ot1),
    .coll_clear_i(clr1), .coll_o(coll1), .coll_cnt_o(cnt1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle8();
    v8 = '0; d8 = '0; t8 = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    v5 = '0; d5 = '0; t5 = '0; clr5 = 1'b0;
    idle8(); clr8 = 1'b0;
    v1 = '0; d1 = '0; t1 = '0; clr1 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    tests++;
    if (ov8 !== 1'b0 || od8 !== '0 || ot8 !== '0 || coll8 !== 1'b0 || cnt8 !== '0) begin
      fails++;
      $display("FAIL reset8: got v=%b d=%h t=%h coll=%b cnt=%0d, want all 0", ov8, od8, ot8, coll8, cnt8);
    end
    tests++;
    if (ov1 !== 1'b0 || od1 !== '0 || coll1 !== 1'b0 || ov5 !== 1'b0 || od5 !== '0) begin
      fails++;
      $display("FAIL reset1_5: got v1=%b d1=%h c1=%b v5=%b d5=%h, want all 0", ov1, od1, coll1, ov5, od5);
    end
    rst = 1'b0;
  endtask

  task automatic test_comb_pad();
    @(negedge clk);
    v5 = 5'b10000; d5 = '0; t5 = '0;
    d5[4*DW +: DW] = 16'hA5A5; t5[4*TW +: TW] = 8'h03;
    #1;
    tests++;
    if (ov5 !== 1'b1 || od5 !== 16'hA5A5 || ot5 !== 8'h03 || coll5 !== 1'b0) begin
      fails++;
      $display("FAIL comb_top_slave: got v=%b d=%h t=%h coll=%b, want 1 a5a5 03 0", ov5, od5, ot5, coll5);
    end
    @(negedge clk);
    v5 = 5'b00110; d5 = '0; t5 = '0;
    d5[1*DW +: DW] = 16'h1111; d5[2*DW +: DW] = 16'h2222;
    t5[1*TW +: TW] = 8'h01;    t5[2*TW +: TW] = 8'h02;
    #1;
    tests++;
    if (ov5 !== 1'b1 || od5 !== 16'h1111 || ot5 !== 8'h01 || coll5 !== 1'b1) begin
      fails++;
      $display("FAIL comb_priority: got v=%b d=%h t=%h coll=%b, want 1 1111 01 1", ov5, od5, ot5, coll5);
    end
    @(negedge clk);
    v5 = '0; d5 = '0; t5 = '0;
    #1;
    tests++;
    if (ov5 !== 1'b0 || od5 !== '0 || ot5 !== '0 || coll5 !== 1'b1) begin
      fails++;
      $display("FAIL comb_idle_sticky: got v=%b d=%h t=%h coll=%b, want 0 0 0 1", ov5, od5, ot5, coll5);
    end
  endtask

  task automatic test_stream();
    logic          ev;
    logic [DW-1:0] ed;
    logic [TW-1:0] et;
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      idle8();
      if (k < 8) begin
        v8[k] = 1'b1;
        d8[k*DW +: DW] = DW'(k);
        t8[k*TW +: TW] = TW'(k + 16);
      end
      #1;
      ev = (k >= 2 && k < 10);
      ed = ev ? DW'(k - 2) : '0;
      et = ev ? TW'(k + 14) : '0;
      tests++;
      if (ov8 !== ev || od8 !== ed || ot8 !== et) begin
        fails++;
        $display("FAIL stream k=%0d: got v=%b d=%h t=%h, want v=%b d=%h t=%h", k, ov8, od8, ot8, ev, ed, et);
      end
    end
    tests++;
    if (coll8 !== 1'b0) begin
      fails++;
      $display("FAIL stream_no_coll: got coll=%b, want 0", coll8);
    end
  endtask

  task automatic test_collision();
    @(negedge clk);
    idle8();
    v8 = 8'b00100100;
    d8[2*DW +: DW] = 16'h0022; d8[5*DW +: DW] = 16'h0055;
    t8[2*TW +: TW] = 8'h02;    t8[5*TW +: TW] = 8'h05;
    #1;
    tests++;
    if (ov8 !== 1'b0 || coll8 !== 1'b0) begin
      fails++;
      $display("FAIL coll_lat0: got v=%b coll=%b, want 0 0", ov8, coll8);
    end
    @(negedge clk); idle8(); #1;
    tests++;
    if (ov8 !== 1'b0 || coll8 !== 1'b0) begin
      fails++;
      $display("FAIL coll_lat1: got v=%b coll=%b, want 0 0", ov8, coll8);
    end
    @(negedge clk); #1;
    tests++;
    if (ov8 !== 1'b1 || od8 !== 16'h0022 || ot8 !== 8'h02 || coll8 !== 1'b1) begin
      fails++;
      $display("FAIL coll_lat2: got v=%b d=%h t=%h coll=%b, want 1 0022 02 1", ov8, od8, ot8, coll8);
    end
    @(negedge clk); #1;
    tests++;
    if (ov8 !== 1'b0 || coll8 !== 1'b1 || cnt8 !== (CNT_EN ? CW'(1) : CW'(0))) begin
      fails++;
      $display("FAIL coll_after: got v=%b coll=%b cnt=%0d, want 0 1 %0d", ov8, coll8, cnt8, CNT_EN ? 1 : 0);
    end
  endtask

  task automatic test_sticky_clear();
    repeat (10) @(negedge clk);
    #1;
    tests++;
    if (coll8 !== 1'b1) begin
      fails++;
      $display("FAIL sticky_hold: got coll=%b, want 1", coll8);
    end
    @(negedge clk); v8 = 8'b00000011;
    @(negedge clk); idle8();
    @(negedge clk); clr8 = 1'b1; #1;
    tests++;
    if (coll8 !== 1'b1 || ov8 !== 1'b1) begin
      fails++;
      $display("FAIL clear_vs_set: got coll=%b v=%b, want 1 1", coll8, ov8);
    end
    @(negedge clk); clr8 = 1'b0; #1;
    tests++;
    if (coll8 !== 1'b1 || cnt8 !== (CNT_EN ? CW'(1) : CW'(0))) begin
      fails++;
      $display("FAIL set_wins: got coll=%b cnt=%0d, want 1 %0d", coll8, cnt8, CNT_EN ? 1 : 0);
    end
    @(negedge clk); clr8 = 1'b1;
    @(negedge clk); clr8 = 1'b0; #1;
    tests++;
    if (coll8 !== 1'b0 || cnt8 !== '0) begin
      fails++;
      $display("FAIL clear_only: got coll=%b cnt=%0d, want 0 0", coll8, cnt8);
    end
  endtask

  task automatic test_saturate();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); v8 = 8'b11000000;
    end
    @(negedge clk); idle8();
    repeat (3) @(negedge clk);
    #1;
    tests++;
    if (coll8 !== 1'b1 || cnt8 !== (CNT_EN ? CW'(3) : CW'(0))) begin
      fails++;
      $display("FAIL saturate: got coll=%b cnt=%0d, want 1 %0d", coll8, cnt8, CNT_EN ? 3 : 0);
    end
    @(negedge clk); clr8 = 1'b1;
    @(negedge clk); clr8 = 1'b0;
  endtask

  task automatic test_reset_midop();
    @(negedge clk);
    idle8(); v8 = 8'b00000001; d8[0 +: DW] = 16'h00AA;
    @(negedge clk);
    idle8(); v8 = 8'b00000011; d8[0 +: DW] = 16'h00BB; rst = 1'b1;
    @(negedge clk);
    idle8(); rst = 1'b0; #1;
    tests++;
    if (ov8 !== 1'b0 || od8 !== '0 || ot8 !== '0 || coll8 !== 1'b0 || cnt8 !== '0) begin
      fails++;
      $display("FAIL midop_reset: got v=%b d=%h t=%h coll=%b cnt=%0d, want all 0", ov8, od8, ot8, coll8, cnt8);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      tests++;
      if (ov8 !== 1'b0 || coll8 !== 1'b0) begin
        fails++;
        $display("FAIL midop_flush k=%0d: got v=%b coll=%b, want 0 0", k, ov8, coll8);
      end
    end
  endtask

  task automatic test_single_slave();
    @(negedge clk);
    v1 = 1'b1; d1 = 16'h0077; t1 = 8'h09; #1;
    tests++;
    if (ov1 !== 1'b0) begin
      fails++;
      $display("FAIL n1_lat0: got v=%b, want 0", ov1);
    end
    @(negedge clk);
    v1 = 1'b0; d1 = '0; t1 = '0; #1;
    tests++;
    if (ov1 !== 1'b1 || od1 !== 16'h0077 || ot1 !== 8'h09 || coll1 !== 1'b0) begin
      fails++;
      $display("FAIL n1_lat1: got v=%b d=%h t=%h coll=%b, want 1 0077 09 0", ov1, od1, ot1, coll1);
    end
    @(negedge clk); #1;
    tests++;
    if (ov1 !== 1'b0 || od1 !== '0) begin
      fails++;
      $display("FAIL n1_idle: got v=%b d=%h, want 0 0", ov1, od1);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_comb_pad();
    test_stream();
    test_collision();
    test_sticky_clear();
    test_saturate();
    test_reset_midop();
    test_single_slave();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
